// File: rtl/store_size_ctrl_pkg.sv
// store_size_ctrl_pkg: size codes and sequencer state encoding shared by the store path.
package store_size_ctrl_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;
endpackage

// File: rtl/store_size_ctrl_if.sv
// store_size_ctrl_if: request handshake and data-memory strobes of the store sequencer.
interface store_size_ctrl_if #(parameter int ADDR_W = 32);
  logic              st_req;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready;
  logic              st_done;
  logic              st_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem_wdata;
  logic [1:0]        ssize_ctrl;
  modport master (
    output st_req, st_size, st_addr, st_data, mem_rdata,
    input  st_ready, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata, ssize_ctrl
  );
  modport slave (
    input  st_req, st_size, st_addr, st_data, mem_rdata,
    output st_ready, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata, ssize_ctrl
  );
endinterface

// File: rtl/store_size_ctrl_merge.sv
// store_size_ctrl_merge: SizeStore merge of register B into the memory word read back (MDR).
module store_size_ctrl_merge
  import store_size_ctrl_pkg::*;
(
  input  logic [31:0] i_mdr,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_sel,
  output logic [31:0] o_wdata
);
  always_comb begin
    o_wdata = (i_sel == SZ_HALF) ? {i_mdr[31:16], i_b[15:0]} :
              (i_sel == SZ_BYTE) ? {i_mdr[31:8], i_b[7:0]} : i_b;
  end
endmodule

// File: rtl/store_size_ctrl.sv
// store_size_ctrl: multicycle sw/sh/sb sequencer; halfword/byte stores do read-modify-write.
// Define STORE_ALIGN_CHECK_EN to reject misaligned word/halfword requests with st_err.
module store_size_ctrl
  import store_size_ctrl_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 32
) (
  input logic clk,
  input logic reset_n,
  store_size_ctrl_if.slave bus
);
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  state_t            r_state;
  logic              r_ready, r_done, r_err, r_rd, r_wr;
  logic [1:0]        r_size, r_ssize;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_b, r_mdr;
  logic              w_bad;
  logic [ADDR_W-1:0] w_word_addr;
  assign w_word_addr = {bus.st_addr[ADDR_W-1:2], 2'b00};
  assign w_bad = (bus.st_size == SZ_RSVD) ||
                 (ALIGN_CHK && bus.st_size == SZ_HALF && bus.st_addr[0]) ||
                 (ALIGN_CHK && bus.st_size == SZ_WORD && bus.st_addr[1:0] != 2'b00);
  // Every output is a register; strobes default low so each asserts for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_ssize    <= SZ_WORD;
      r_size     <= SZ_WORD;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_b        <= '0;
      r_mdr      <= '0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ssize <= SZ_WORD;
      case (r_state)
        IDLE: if (bus.st_req) begin
          r_ready    <= 1'b0;
          r_size     <= bus.st_size;
          r_b        <= bus.st_data;
          r_mem_addr <= w_word_addr;
          if (w_bad) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else if (bus.st_size == SZ_WORD) begin
            r_state <= WRITE;
            r_wr    <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
            r_rd    <= 1'b1;
          end
        end
        READ: begin
          r_state <= WAIT;
          r_cnt   <= 3'(READ_LAT - 1);
        end
        WAIT: if (r_cnt == 3'd0) begin
          r_mdr   <= bus.mem_rdata;
          r_state <= WRITE;
          r_wr    <= 1'b1;
          r_done  <= 1'b1;
          r_ssize <= r_size;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
  store_size_ctrl_merge u_merge (
    .i_mdr   (r_mdr),
    .i_b     (r_b),
    .i_sel   (r_ssize),
    .o_wdata (bus.mem_wdata)
  );
  assign bus.st_ready   = r_ready;
  assign bus.st_done    = r_done;
  assign bus.st_err     = r_err;
  assign bus.mem_rd     = r_rd;
  assign bus.mem_wr     = r_wr;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.ssize_ctrl = r_ssize;
endmodule

// File: tb/tb_store_size_ctrl.sv
// tb_store_size_ctrl: directed vector table plus reset-in-WAIT and back-to-back sequences.
module tb_store_size_ctrl;
  localparam int RL = 2;
  localparam int AW = 32;
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mem_word;
    bit          exp_err;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int overlap = 0;
  logic [31:0] mem [64];
  logic [31:0] pd [RL];
  bit          pv [RL];
  vec_t vt [8];
  store_size_ctrl_if #(.ADDR_W(AW)) bus ();
  store_size_ctrl #(.READ_LAT(RL), .ADDR_W(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  // Memory returns data exactly RL cycles after mem_rd is sampled; poison otherwise.
  always @(posedge clk) begin
    pv[0] <= bus.mem_rd;
    pd[0] <= mem[bus.mem_addr[7:2]];
    for (int k = 1; k < RL; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    if (bus.mem_rd && bus.mem_wr) overlap <= overlap + 1;
  end
  assign bus.mem_rdata = pv[RL-1] ? pd[RL-1] : 32'hBAD0_BAD0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, ev_cyc, rds, exp_cyc;
    bit ev_err;
    logic [31:0] wd, wa;
    logic [1:0] ss;
    logic dn;
    string nm;
    nm = $sformatf("v%0d", idx);
    mem[v.addr[7:2]] = v.mem_word;
    @(posedge clk); #1;
    chk({nm, "_ready_idle"}, 32'(bus.st_ready), 32'd1);
    bus.st_req = 1'b1; bus.st_size = v.size; bus.st_addr = v.addr; bus.st_data = v.data;
    @(posedge clk); #1;
    bus.st_req = 1'b0; bus.st_size = 2'b00; bus.st_addr = 32'hFFFF_FFFF; bus.st_data = 32'h0;
    cyc = 1; ev_cyc = 99; rds = 0; ev_err = 1'b0; wd = '0; wa = '0; ss = '0; dn = 1'b0;
    chk({nm, "_ready_busy"}, 32'(bus.st_ready), 32'd0);
    while (cyc < 20 && ev_cyc == 99) begin
      if (bus.mem_rd) rds++;
      if (bus.mem_wr || bus.st_err) begin
        ev_cyc = cyc; ev_err = bus.st_err; wd = bus.mem_wdata; wa = bus.mem_addr;
        ss = bus.ssize_ctrl; dn = bus.st_done;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    exp_cyc = (v.exp_err || v.size == 2'b00) ? 1 : 2 + RL;
    chk({nm, "_latency"}, 32'(ev_cyc), 32'(exp_cyc));
    chk({nm, "_err"}, 32'(ev_err), 32'(v.exp_err));
    chk({nm, "_rd_count"}, 32'(rds), (v.exp_err || v.size == 2'b00) ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      chk({nm, "_wdata"}, wd, v.exp_wdata);
      chk({nm, "_addr"}, wa, v.exp_addr);
      chk({nm, "_ssize"}, 32'(ss), 32'(v.size));
      chk({nm, "_done"}, 32'(dn), 32'd1);
    end
    @(posedge clk); #1;
    chk({nm, "_after"}, {28'd0, bus.st_ready, bus.mem_wr, bus.st_err, bus.st_done}, 32'h8);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int wr_cnt, cyc, first_wr, second_wr;
    logic [31:0] w1, a1, w2, a2;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus.st_req = 1'b0; bus.st_size = 2'b00; bus.st_addr = '0; bus.st_data = '0;
    vt[0] = '{2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0,  32'hDEADBEEF, 32'h10};
    vt[1] = '{2'b01, 32'h20, 32'hAAAABBBB, 32'h11223344, 1'b0,  32'h1122BBBB, 32'h20};
    vt[2] = '{2'b10, 32'h24, 32'h000000CC, 32'h55667788, 1'b0,  32'h556677CC, 32'h24};
    vt[3] = '{2'b11, 32'h28, 32'h12345678, 32'h0,        1'b1,  32'h0,        32'h0};
    vt[4] = '{2'b01, 32'h21, 32'h0000BEEF, 32'h11223344, ALIGN, 32'h1122BEEF, 32'h20};
    vt[5] = '{2'b10, 32'h27, 32'hFFFFFF01, 32'hA5A5A5A5, 1'b0,  32'hA5A5A501, 32'h24};
    vt[6] = '{2'b00, 32'h12, 32'hCAFEF00D, 32'h0,        ALIGN, 32'hCAFEF00D, 32'h10};
    vt[7] = '{2'b01, 32'h3C, 32'h12345678, 32'h0,        1'b0,  32'h00005678, 32'h3C};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_strobes", {28'd0, bus.mem_rd, bus.mem_wr, bus.st_err, bus.st_done}, 32'd0);
    chk("rst_ssize", 32'(bus.ssize_ctrl), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(vt[i], i);
    // Reset while the read is in flight: no write may follow.
    mem[8] = 32'h11223344;
    @(posedge clk); #1;
    bus.st_req = 1'b1; bus.st_size = 2'b01; bus.st_addr = 32'h20; bus.st_data = 32'h0000FFFF;
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrst_ready", 32'(bus.st_ready), 32'd1);
    chk("midrst_addr", bus.mem_addr, 32'd0);
    wr_cnt = 0;
    for (int i = 0; i < RL + 3; i++) begin
      if (bus.mem_wr || bus.mem_rd) wr_cnt++;
      @(posedge clk); #1;
    end
    chk("midrst_no_access", 32'(wr_cnt), 32'd0);
    run_vec(vt[0], 100);
    // Request held high: second accepted only once back in IDLE, first unaffected.
    mem[8] = 32'h11223344;
    @(posedge clk); #1;
    bus.st_req = 1'b1; bus.st_size = 2'b01; bus.st_addr = 32'h20; bus.st_data = 32'hAAAABBBB;
    @(posedge clk); #1;
    bus.st_size = 2'b00; bus.st_addr = 32'h30; bus.st_data = 32'h12345678;
    cyc = 1; first_wr = 0; second_wr = 0; w1 = '0; a1 = '0; w2 = '0; a2 = '0;
    while (cyc < 30 && second_wr == 0) begin
      if (bus.mem_wr) begin
        if (first_wr == 0) begin first_wr = cyc; w1 = bus.mem_wdata; a1 = bus.mem_addr; end
        else begin second_wr = cyc; w2 = bus.mem_wdata; a2 = bus.mem_addr; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.st_req = 1'b0;
    chk("b2b_first_cyc", 32'(first_wr), 32'(2 + RL));
    chk("b2b_first_wdata", w1, 32'h1122BBBB);
    chk("b2b_first_addr", a1, 32'h20);
    chk("b2b_second_cyc", 32'(second_wr), 32'(4 + RL));
    chk("b2b_second_wdata", w2, 32'h12345678);
    chk("b2b_second_addr", a2, 32'h30);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_size_ctrl.md
Name: store_size_ctrl

Overview:
- Multicycle sequencer for sw/sh/sb stores.
- Word stores write register B directly.
- Halfword and byte stores do a read-modify-write: read the memory word, latch it in an internal MDR, then drive the SizeStore merge select and write the merged word back.
- Sits between the main control unit and data memory; owns the SizeStore select and the memory strobes while a store is in flight.

Parameters:
- READ_LAT, 2, memory read latency in cycles (mem_rdata valid READ_LAT cycles after mem_rd is sampled high); legal range 1..7.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- st_req  in  1  store request; sampled only when st_ready=1.
- st_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  32  register B value.
- st_ready  out  1  1 in IDLE only.
- st_done  out  1  one-cycle pulse when the write is issued.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_rdata  in  32  memory read data.
- mem_wdata  out  32  merged write data.
- ssize_ctrl  out  2  merge select: 00 pass B, 01 half, 10 byte.
- st_err  out  1  one-cycle pulse, reserved-size or misaligned request (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a clk edge), regardless of state:
  - state=IDLE, st_ready=1.
  - st_done, st_err, mem_rd, mem_wr = 0.
  - ssize_ctrl=00; mem_addr, mem_wdata, MDR, latency counter = 0.
  - An in-flight read is abandoned with no write.
- IDLE, on st_req=1:
  - Latch addr, data and size into internal registers.
  - st_size=00 -> WRITE.
  - st_size 01/10 -> READ.
  - st_size=11 -> ERR.
- READ:
  - mem_rd=1 for exactly one cycle, mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Counter loads READ_LAT-1 -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Counter at 0 -> MDR <= mem_rdata -> WRITE.
- WRITE:
  - mem_wr=1 for exactly one cycle, mem_addr = word address.
  - ssize_ctrl = latched size.
  - mem_wdata = merge(MDR, B): 00 -> B; 01 -> {MDR[31:16],B[15:0]}; 10 -> {MDR[31:8],B[7:0]}.
  - st_done=1 in this cycle -> IDLE.
- ERR: st_err=1 for one cycle, no memory access -> IDLE.
- Latency:
  - Word store: 2 cycles from request acceptance to IDLE, write in the cycle after acceptance.
  - Half/byte: acceptance + 1 (READ) + READ_LAT (WAIT) + 1 (WRITE) cycles.
- Request handling:
  - st_req while st_ready=0 is ignored, not queued.
  - Inputs are used only at acceptance; later changes have no effect.
- Outputs are registered (Moore).
- mem_rd and mem_wr are never high in the same cycle.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined: in IDLE, a halfword with addr[0]=1 or a word with addr[1:0]!=00 goes to ERR; no memory access. Bytes are always aligned.
- Undefined: the low address bits are ignored (word-aligned access); only size 11 raises st_err.

Decomposition:
- Shared package:
  - Size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - State encoding IDLE/READ/WAIT/WRITE/ERR.
- Sub-module: the team's existing SizeStore merge block, instantiated for mem_wdata, fed by the internal MDR, latched B and ssize_ctrl.

Test Plan:
- Word store: st_size=00, addr=0x10, data=0xDEADBEEF -> next cycle mem_wr=1, mem_wdata=0xDEADBEEF, st_done=1, mem_rd never asserted.
- Halfword: mem[0x20]=0x11223344, data=0xAAAABBBB, READ_LAT=2 -> mem_rd once, write 4 cycles after acceptance, mem_wdata=0x1122BBBB, ssize_ctrl=01.
- Byte: mem[0x24]=0x55667788, data=0x000000CC -> mem_wdata=0x556677CC, ssize_ctrl=10.
- Reset mid-operation: reset_n=0 during WAIT -> next cycle st_ready=1, no mem_wr issued; a following word store completes normally.
- Error cases:
  - st_size=11 -> st_err pulse, no mem_rd/mem_wr.
  - With STORE_ALIGN_CHECK_EN, halfword at 0x21 -> st_err pulse.
  - Without the macro, halfword at 0x21 -> normal RMW at 0x20.
- Back-to-back: st_req held high with a second request queued behind the first -> second accepted only on the cycle st_ready=1; the first's data is unaffected by input changes during the operation.
